memory_nc: RTL and testbench
============================

// Module: memory_nc
// PURPOSE
//  Parametrised single-port, byte-addressable data memory for the cache/memory subsystem.
//  Writes commit in one cycle. Reads are fully pipelined with a fixed READ_LAT-cycle latency.
//  One request is accepted per cycle, with no stall. A tag echoes each read to its requester (I-/D-cache arbiter).
// PARAMETERS
//  ADDR_WIDTH  16  byte-address width
//  DATA_WIDTH  16  word width in bits; multiple of 8, power of two
//  READ_LAT    4   request-to-data_valid cycles; legal range 1..16
//  TAG_WIDTH   2   requester tag width; echoed with read data
// PORTS
//  clk         in   1              rising-edge clock
//  rst_n       in   1              asynchronous, active-low reset
//  enable      in   1              request strobe
//  wr          in   1              1 = write, 0 = read (qualified by enable)
//  addr        in   ADDR_WIDTH     byte address; word index = addr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)]
//  data_in     in   DATA_WIDTH     write data
//  byte_en     in   DATA_WIDTH/8   write byte strobes; ignored on reads
//  tag_in      in   TAG_WIDTH      read tag
//  data_out    out  DATA_WIDTH     read data
//  data_valid  out  1              data_out/tag_out/misalign valid this cycle
//  tag_out     out  TAG_WIDTH      tag of the returned read
//  misalign    out  1              returned read had nonzero addr low bits
// BEHAVIOUR
//  Reset:
//   - rst_n low clears all pipeline valid bits; data_out, data_valid, tag_out and misalign become 0.
//   - The storage array is NOT cleared.
//   - Reads in flight when reset is asserted are dropped and never return.
//  Write (enable & wr):
//   - At the clock edge, each byte lane with byte_en[i]=1 is written.
//   - No response is produced.
//   - addr low bits are ignored.
//  Read (enable & ~wr):
//   - The array is sampled at the issue edge.
//   - Data, tag and misalign enter stage 1.
//   - They shift one stage per cycle and appear at the outputs exactly READ_LAT cycles after issue, with data_valid=1 for one cycle.
//  Throughput and ordering:
//   - Back-to-back reads return back-to-back, in order.
//   - With no read issued, data_valid=0 and data_out holds 0. A bubble returns zeros.
//  Read-after-write:
//   - A read issued in the same cycle as a write is impossible (single port).
//   - A read issued the cycle after a write sees the new data.
//  Misaligned read: the word at the truncated index is returned and misalign=1 accompanies it. This is not an error stop.
//  The pipeline is a valid-qualified shift register. It has no backpressure; the consumer must accept every beat.
// CONFIGURATION
//  MEMNC_WR_FWD_EN defined:
//   - A write whose word index matches an in-flight read updates that read's pipeline data for the enabled byte lanes, in the same cycle.
//   - The returned data therefore reflects the array contents at delivery time.
//  MEMNC_WR_FWD_EN undefined: returned data is the array snapshot taken at the issue edge.
// STRUCTURE
//  Package memnc_pkg holds:
//   - localparams BYTES = DATA_WIDTH/8 and OFF_BITS = log2(BYTES);
//   - typedef memnc_beat_t, a struct {valid, tag, misalign, word_idx, data}.
//  Sub-module memnc_delay_line holds the READ_LAT-deep array of memnc_beat_t and owns the reset of the valid bits.
//   - Forwarding compares word_idx at every stage.
//  The top level holds the storage array and the byte-lane write logic.
// TESTING
//  1. Reset, then read addr 0x0010 with tag 2 -> data_valid=1 exactly 4 cycles later, with tag_out=2 and the stored word.
//  2. Four back-to-back reads of 0x0000/02/04/06 -> four consecutive data_valid beats in order; data_valid=0 on the cycle after.
//  3. Write 0xBEEF to 0x0020 with byte_en=2'b01, then read 0x0020 -> the low byte is 0xEF and the high byte keeps its old value.
//  4. Read 0x0031 -> the word at 0x0030 is returned with misalign=1.
//  5. Read 0x0040 (old value 0x1111), write 0x2222 to 0x0040 the next cycle -> returns 0x1111 without the macro, 0x2222 with MEMNC_WR_FWD_EN.
//  6. Issue 3 reads, then pulse rst_n low for 1 cycle mid-flight -> no data_valid is ever seen for them and all outputs are 0; array contents are intact on re-read.

Source files
------------

// File: rtl/memnc_pkg.sv
// Shared types and widths for the memory_nc data memory.
// Beat struct carries one read through the fixed-latency return pipeline.
package memnc_pkg;

    localparam int MEMNC_AW  = 16;
    localparam int MEMNC_DW  = 16;
    localparam int MEMNC_TW  = 2;
    localparam int BYTES     = MEMNC_DW / 8;
    localparam int OFF_BITS  = $clog2(BYTES);
    localparam int WIDX_BITS = MEMNC_AW - OFF_BITS;

    typedef struct packed {
        logic                 valid;
        logic [MEMNC_TW-1:0]  tag;
        logic                 misalign;
        logic [WIDX_BITS-1:0] word_idx;
        logic [MEMNC_DW-1:0]  data;
    } memnc_beat_t;

    function automatic logic [MEMNC_DW-1:0] merge_bytes(
        input logic [MEMNC_DW-1:0] old_w,
        input logic [MEMNC_DW-1:0] new_w,
        input logic [BYTES-1:0]    be
    );
        logic [MEMNC_DW-1:0] res;
        res = old_w;
        for (int b = 0; b < BYTES; b++) begin
            if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/memnc_delay_line.sv
// Valid-qualified read-return shift register, LAT stages deep.
// Optional write forwarding patches in-flight beats that match the written word.
module memnc_delay_line
    import memnc_pkg::*;
#(
    parameter int LAT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  memnc_beat_t          in_beat,
    input  logic                 fwd_we,
    input  logic [WIDX_BITS-1:0] fwd_idx,
    input  logic [MEMNC_DW-1:0]  fwd_data,
    input  logic [BYTES-1:0]     fwd_be,
    output memnc_beat_t          out_beat
);

    memnc_beat_t beats_q [LAT];
    memnc_beat_t beats_d [LAT];

    // The beat leaving at the output this cycle is already delivered, so it is not patched.
    always_comb begin
        beats_d[0] = in_beat;
        for (int k = 1; k < LAT; k++) begin
            beats_d[k] = beats_q[k-1];
            if (fwd_we && beats_q[k-1].valid
                && beats_q[k-1].word_idx == fwd_idx) begin
                beats_d[k].data = merge_bytes(beats_q[k-1].data, fwd_data, fwd_be);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LAT; k++) begin
                beats_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < LAT; k++) begin
                beats_q[k] <= beats_d[k];
            end
        end
    end

    assign out_beat = beats_q[LAT-1];

endmodule

// File: rtl/memory_nc.sv
// Single-port byte-addressable data memory with fixed-latency pipelined reads.
// Define MEMNC_WR_FWD_EN to forward writes into reads still in flight.
module memory_nc
    import memnc_pkg::*;
#(
    parameter int ADDR_WIDTH = MEMNC_AW,
    parameter int DATA_WIDTH = MEMNC_DW,
    parameter int READ_LAT   = 4,
    parameter int TAG_WIDTH  = MEMNC_TW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    wr,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    input  logic [TAG_WIDTH-1:0]    tag_in,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    data_valid,
    output logic [TAG_WIDTH-1:0]    tag_out,
    output logic                    misalign
);

    localparam int WORDS = 2 ** WIDX_BITS;

    logic [DATA_WIDTH-1:0] mem_q [WORDS];

    logic                 we;
    logic                 re;
    logic                 fwd_we;
    logic [WIDX_BITS-1:0] idx;
    memnc_beat_t          in_beat;
    memnc_beat_t          out_beat;

    assign we  = enable & wr;
    assign re  = enable & ~wr;
    assign idx = addr[ADDR_WIDTH-1:OFF_BITS];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (byte_en[b]) mem_q[idx][8*b +: 8] <= data_in[8*b +: 8];
            end
        end
    end

    always_comb begin
        in_beat = '0;
        if (re) begin
            in_beat.valid    = 1'b1;
            in_beat.tag      = tag_in;
            in_beat.misalign = (addr & ADDR_WIDTH'(BYTES - 1)) != '0;
            in_beat.word_idx = idx;
            in_beat.data     = mem_q[idx];
        end
    end

`ifdef MEMNC_WR_FWD_EN
    assign fwd_we = we;
`else
    assign fwd_we = 1'b0;
`endif

    memnc_delay_line #(
        .LAT (READ_LAT)
    ) u_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_beat  (in_beat),
        .fwd_we   (fwd_we),
        .fwd_idx  (idx),
        .fwd_data (data_in),
        .fwd_be   (byte_en),
        .out_beat (out_beat)
    );

    assign data_out   = out_beat.data;
    assign data_valid = out_beat.valid;
    assign tag_out    = out_beat.tag;
    assign misalign   = out_beat.misalign;

endmodule

// File: tb/tb_memory_nc.sv
// Directed self-checking bench for memory_nc (READ_LAT = 4).
// Expected data comes from the values this bench writes.
module tb_memory_nc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [1:0]  byte_en;
    logic [1:0]  tag_in;
    logic [15:0] data_out;
    logic        data_valid;
    logic [1:0]  tag_out;
    logic        misalign;

    int tests = 0;
    int fails = 0;

    memory_nc #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (16),
        .READ_LAT   (4),
        .TAG_WIDTH  (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .wr         (wr),
        .addr       (addr),
        .data_in    (data_in),
        .byte_en    (byte_en),
        .tag_in     (tag_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .tag_out    (tag_out),
        .misalign   (misalign)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, ".valid"}, 32'(data_valid), 32'd0);
        chk({name, ".data"}, 32'(data_out), 32'd0);
        chk({name, ".tag"}, 32'(tag_out), 32'd0);
        chk({name, ".mis"}, 32'(misalign), 32'd0);
    endtask

    task automatic write(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be);
        enable  = 1'b1;
        wr      = 1'b1;
        addr    = a;
        data_in = d;
        byte_en = be;
        tick();
        enable  = 1'b0;
        wr      = 1'b0;
        byte_en = 2'b00;
    endtask

    task automatic read_issue(input logic [15:0] a, input logic [1:0] t);
        enable = 1'b1;
        wr     = 1'b0;
        addr   = a;
        tag_in = t;
        byte_en = 2'b11;
        tick();
        enable = 1'b0;
        byte_en = 2'b00;
    endtask

    task automatic chk_beat(input string name, input logic [15:0] d,
                            input logic [1:0] t, input logic m);
        chk({name, ".valid"}, 32'(data_valid), 32'd1);
        chk({name, ".data"}, 32'(data_out), 32'(d));
        chk({name, ".tag"}, 32'(tag_out), 32'(t));
        chk({name, ".mis"}, 32'(misalign), 32'(m));
    endtask

    task automatic read_expect(input string name, input logic [15:0] a,
                               input logic [1:0] t, input logic [15:0] d,
                               input logic m);
        read_issue(a, t);
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("%s.early%0d", name, i), 32'(data_valid), 32'd0);
            tick();
        end
        chk_beat(name, d, t, m);
        tick();
        chk_idle({name, ".after"});
    endtask

    logic [15:0] fwd_exp;

    initial begin
        rst_n   = 1'b0;
        enable  = 1'b0;
        wr      = 1'b0;
        addr    = '0;
        data_in = '0;
        byte_en = '0;
        tag_in  = '0;
        tick();
        tick();
        chk_idle("reset");
        rst_n = 1'b1;
        tick();

        write(16'h0010, 16'hA5C3, 2'b11);
        write(16'h0000, 16'h1000, 2'b11);
        write(16'h0002, 16'h1002, 2'b11);
        write(16'h0004, 16'h1004, 2'b11);
        write(16'h0006, 16'h1006, 2'b11);
        write(16'h0020, 16'h1234, 2'b11);
        write(16'h0030, 16'h3030, 2'b11);
        write(16'h0040, 16'h1111, 2'b11);
        tick();
        chk_idle("write_no_resp");

        read_expect("rd_0010", 16'h0010, 2'd2, 16'hA5C3, 1'b0);

        read_issue(16'h0000, 2'd0);
        read_issue(16'h0002, 2'd1);
        read_issue(16'h0004, 2'd2);
        read_issue(16'h0006, 2'd3);
        chk_beat("b2b0", 16'h1000, 2'd0, 1'b0);
        tick();
        chk_beat("b2b1", 16'h1002, 2'd1, 1'b0);
        tick();
        chk_beat("b2b2", 16'h1004, 2'd2, 1'b0);
        tick();
        chk_beat("b2b3", 16'h1006, 2'd3, 1'b0);
        tick();
        chk_idle("b2b_end");

        write(16'h0020, 16'hBEEF, 2'b01);
        read_expect("be_lo", 16'h0020, 2'd1, 16'h12EF, 1'b0);
        write(16'h0030, 16'hAB00, 2'b10);
        read_expect("be_hi", 16'h0030, 2'd2, 16'hAB30, 1'b0);

        read_expect("misalign", 16'h0031, 2'd1, 16'hAB30, 1'b1);

`ifdef MEMNC_WR_FWD_EN
        fwd_exp = 16'h2222;
`else
        fwd_exp = 16'h1111;
`endif
        read_issue(16'h0040, 2'd3);
        write(16'h0040, 16'h2222, 2'b11);
        chk("raw.early", 32'(data_valid), 32'd0);
        tick();
        chk("raw.early2", 32'(data_valid), 32'd0);
        tick();
        chk_beat("raw_fwd", fwd_exp, 2'd3, 1'b0);
        tick();
        read_expect("raw_new", 16'h0040, 2'd0, 16'h2222, 1'b0);

        read_issue(16'h0000, 2'd1);
        read_issue(16'h0002, 2'd2);
        read_issue(16'h0004, 2'd3);
        rst_n = 1'b0;
        #1;
        chk_idle("rst_async");
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk_idle($sformatf("rst_drop%0d", i));
            tick();
        end
        read_expect("keep_0002", 16'h0002, 2'd2, 16'h1002, 1'b0);
        read_expect("keep_0010", 16'h0010, 2'd0, 16'hA5C3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
